// File: rtl/hilo_ctrl_if.sv
// HI/LO sequencer bus: EX-stage issue signals in, stall and HI/LO write port out.
interface hilo_ctrl_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        div_busy;
    logic [1:0]  we;
    logic [31:0] hiin;
    logic [31:0] loin;

    // Pipeline side: issues operations and watches stall and the write port
    modport master (
        output op_valid, op, src_a, src_b, flush,
        input  stall, div_busy, we, hiin, loin
    );

    // Sequencer side
    modport slave (
        input  op_valid, op, src_a, src_b, flush,
        output stall, div_busy, we, hiin, loin
    );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO write sequencer: single-cycle multiply, 32-step restoring divide,
// MTHI/MTLO, with pipeline stall while a divide is in flight.
module hilo_ctrl (
    input  logic       clk,
    input  logic       rst,
    hilo_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [1:0]  r_state;
    logic [4:0]  r_count;
    logic [1:0]  r_we;
    logic [31:0] r_hiin;
    logic [31:0] r_loin;

    // Divider datapath: r_quo starts as the dividend magnitude and is shifted
    // out MSB-first while quotient bits are shifted in at the bottom.
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic        r_qneg;
    logic        r_rneg;

    logic        w_issue;
    logic        w_is_div;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [31:0] w_q_fin;
    logic [31:0] w_r_fin;

    assign w_issue  = (r_state == S_IDLE) & bus.op_valid & ~bus.flush;
    assign w_is_div = (bus.op == OP_DIV) | (bus.op == OP_DIVU);

    assign w_abs_a  = bus.src_a[31] ? -bus.src_a : bus.src_a;
    assign w_abs_b  = bus.src_b[31] ? -bus.src_b : bus.src_b;

    assign w_prod_s = $signed({{32{bus.src_a[31]}}, bus.src_a}) *
                      $signed({{32{bus.src_b[31]}}, bus.src_b});
    assign w_prod_u = {32'd0, bus.src_a} * {32'd0, bus.src_b};

    // Restoring step: the partial remainder is always below the divisor, so
    // when the trial subtraction succeeds the 32-bit difference is exact.
    // A zero divisor always "succeeds", leaving all-ones quotient and the
    // dividend in the remainder.
    assign w_shift  = {r_rem, r_quo[31]};
    assign w_ge     = w_shift >= {1'b0, r_dvs};
    assign w_diff   = w_shift[31:0] - r_dvs;

    assign w_q_fin  = r_qneg ? -r_quo : r_quo;
    assign w_r_fin  = r_rneg ? -r_rem : r_rem;

    assign bus.stall    = ~rst & (((r_state != S_IDLE) & ~bus.flush) |
                                  (w_issue & w_is_div));
    assign bus.div_busy = (r_state != S_IDLE);
    assign bus.we       = r_we;
    assign bus.hiin     = r_hiin;
    assign bus.loin     = r_loin;

    // Control FSM, iteration counter and registered HI/LO write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= 5'd0;
            r_we    <= 2'b00;
            r_hiin  <= 32'd0;
            r_loin  <= 32'd0;
        end else begin
            r_we   <= 2'b00;
            r_hiin <= 32'd0;
            r_loin <= 32'd0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        case (bus.op)
                            OP_MULT: begin
                                r_we   <= 2'b11;
                                r_hiin <= w_prod_s[63:32];
                                r_loin <= w_prod_s[31:0];
                            end
                            OP_MULTU: begin
                                r_we   <= 2'b11;
                                r_hiin <= w_prod_u[63:32];
                                r_loin <= w_prod_u[31:0];
                            end
                            OP_DIV, OP_DIVU: begin
                                r_count <= 5'd0;
                                r_state <= S_RUN;
                            end
                            OP_MTHI: begin
                                r_we   <= 2'b10;
                                r_hiin <= bus.src_a;
                            end
                            OP_MTLO: begin
                                r_we   <= 2'b01;
                                r_loin <= bus.src_a;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= r_count + 5'd1;
                        if (r_count == 5'd31)
                            r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!bus.flush) begin
                        r_we   <= 2'b11;
                        r_hiin <= w_r_fin;
                        r_loin <= w_q_fin;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Divider operand latch on issue and one shift-subtract step per RUN cycle
    always_ff @(posedge clk) begin
        if (w_issue && bus.op == OP_DIV) begin
            r_quo  <= w_abs_a;
            r_dvs  <= w_abs_b;
            r_rem  <= 32'd0;
            // A zero divisor yields an all-ones quotient regardless of sign.
            r_qneg <= (bus.src_a[31] ^ bus.src_b[31]) & (|bus.src_b);
            r_rneg <= bus.src_a[31];
        end else if (w_issue && bus.op == OP_DIVU) begin
            r_quo  <= bus.src_a;
            r_dvs  <= bus.src_b;
            r_rem  <= 32'd0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_rem <= w_ge ? w_diff : w_shift[31:0];
            r_quo <= {r_quo[30:0], w_ge};
        end
    end
endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: directed test-plan steps plus random
// operations checked against an arithmetic reference model.
module tb_hilo_ctrl;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    hilo_ctrl_if bus ();

    hilo_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference results straight from the MIPS HI/LO definitions
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [1:0] ewe, output logic [31:0] ehi, output logic [31:0] elo);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        logic [63:0] q;
        logic [63:0] r;
        ewe = 2'b00; ehi = 32'd0; elo = 32'd0;
        case (op)
            3'd1: begin
                p = longint'($signed(a)) * longint'($signed(b));
                ewe = 2'b11; ehi = p[63:32]; elo = p[31:0];
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                ewe = 2'b11; ehi = p[63:32]; elo = p[31:0];
            end
            3'd3, 3'd4: begin
                ewe = 2'b11;
                if (b == 32'd0) begin
                    ehi = a; elo = 32'hFFFF_FFFF;
                end else if (op == 3'd3) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q = sa / sb;
                    r = sa % sb;
                    ehi = r[31:0]; elo = q[31:0];
                end else begin
                    ehi = a % b; elo = a / b;
                end
            end
            3'd5: begin ewe = 2'b10; ehi = a; end
            3'd6: begin ewe = 2'b01; elo = a; end
            default: ;
        endcase
    endtask

    // Issue one op at the current cycle and check stall, latency and write
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [1:0]  ewe;
        logic [31:0] ehi;
        logic [31:0] elo;
        bit          isdiv;
        int          lat;
        int          bad;
        model(op, a, b, ewe, ehi, elo);
        isdiv = (op == 3'd3) || (op == 3'd4);
        lat   = isdiv ? 34 : 1;
        bus.op_valid = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
        #1;
        chk("issue_stall", {31'd0, bus.stall}, {31'd0, isdiv});
        @(posedge clk); #1;
        bus.op_valid = 1'b0; bus.op = 3'd0;
        bad = 0;
        for (int k = 1; k < lat; k++) begin
            if (bus.stall !== 1'b1 || bus.we !== 2'b00 || bus.div_busy !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        if (isdiv) chk("div_wait_cycles", bad, 0);
        chk("we", {30'd0, bus.we}, {30'd0, ewe});
        chk("hiin", bus.hiin, ehi);
        chk("loin", bus.loin, elo);
        chk("stall_after", {31'd0, bus.stall}, 32'd0);
    endtask

    initial begin
        int bad;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.op_valid = 1'b0; bus.op = 3'd0; bus.src_a = 32'd0; bus.src_b = 32'd0; bus.flush = 1'b0;
        #2;
        chk("rst_we", {30'd0, bus.we}, 32'd0);
        chk("rst_hiin", bus.hiin, 32'd0);
        chk("rst_loin", bus.loin, 32'd0);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_busy", {31'd0, bus.div_busy}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Multiply and divide examples including sign and zero-divisor corners
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        do_op(3'd3, 32'd7, 32'hFFFF_FFFE);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd4, 32'hFFFF_FFFF, 32'h10);
        do_op(3'd4, 32'd5, 32'd0);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd0);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd0, 32'h1111, 32'h2222);
        do_op(3'd7, 32'h3333, 32'h4444);

        // Flush ten cycles into a divide, then an MTHI right after
        bus.op_valid = 1'b1; bus.op = 3'd3; bus.src_a = 32'd100; bus.src_b = 32'd7;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        bad = 0;
        repeat (9) begin
            if (bus.we !== 2'b00) bad++;
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        #1;
        chk("flush_stall_low", {31'd0, bus.stall}, 32'd0);
        chk("flush_busy_before_edge", {31'd0, bus.div_busy}, 32'd1);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        if (bus.we !== 2'b00) bad++;
        chk("flush_no_write", bad, 0);
        chk("flush_idle", {31'd0, bus.div_busy}, 32'd0);
        do_op(3'd5, 32'h1234, 32'd0);

        // Flush coinciding with an issue discards it
        bus.op_valid = 1'b1; bus.op = 3'd1; bus.src_a = 32'd3; bus.src_b = 32'd5; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0; bus.flush = 1'b0;
        chk("flush_issue_we", {30'd0, bus.we}, 32'd0);

        // Asynchronous reset in the middle of a divide
        bus.op_valid = 1'b1; bus.op = 3'd4; bus.src_a = 32'd999; bus.src_b = 32'd3;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("arst_we", {30'd0, bus.we}, 32'd0);
        chk("arst_stall", {31'd0, bus.stall}, 32'd0);
        chk("arst_busy", {31'd0, bus.div_busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(3'd6, 32'hABCD, 32'd0);

        // MTHI, MTLO, MULT in consecutive cycles
        bus.op_valid = 1'b1; bus.op = 3'd5; bus.src_a = 32'd11;
        @(posedge clk); #1;
        bus.op = 3'd6; bus.src_a = 32'd22;
        chk("seq_we0", {30'd0, bus.we}, 32'd2);
        chk("seq_hi0", bus.hiin, 32'd11);
        @(posedge clk); #1;
        bus.op = 3'd1; bus.src_a = 32'd3; bus.src_b = 32'd4;
        chk("seq_we1", {30'd0, bus.we}, 32'd1);
        chk("seq_lo1", bus.loin, 32'd22);
        chk("seq_stall1", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        bus.op_valid = 1'b0; bus.op = 3'd0;
        chk("seq_we2", {30'd0, bus.we}, 32'd3);
        chk("seq_lo2", bus.loin, 32'd12);
        chk("seq_hi2", bus.hiin, 32'd0);
        @(posedge clk); #1;
        chk("seq_we3", {30'd0, bus.we}, 32'd0);

        // Random operations, issued back-to-back
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(1, 6));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = rb >> $urandom_range(16, 31);
                2: ra = ra | 32'h8000_0000;
                default: ;
            endcase
            do_op(rop, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Multiply/divide sequencer that owns all writes into the HI/LO register pair of the MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage. It computes products in one registered cycle and quotients/remainders with a 32-iteration radix-2 divider, and stalls the pipeline while a divide is in flight. Its we/hiin/loin outputs connect directly to the HI/LO register's write port.

## Interface
- No parameters (datapath fixed at 32 bits).
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  EX-stage issue strobe for a HI/LO-writing instruction.
- op  in  3  3'd1 MULT, 3'd2 MULTU, 3'd3 DIV, 3'd4 DIVU, 3'd5 MTHI, 3'd6 MTLO; other codes are no-ops.
- src_a  in  32  rs value (multiplicand, dividend, or MTHI/MTLO data).
- src_b  in  32  rt value (multiplier or divisor).
- flush  in  1  pipeline flush (exception); cancels any issue or divide in flight.
- stall  out  1  hold IF/ID/EX while a divide is pending.
- div_busy  out  1  high in RUN or DONE.
- we  out  2  [1] HI write, [0] LO write; registered.
- hiin  out  32  HI write data; registered.
- loin  out  32  LO write data; registered.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: we=0, hiin=0, loin=0, div_busy=0, stall=0, iteration count=0.
- Issue is accepted only in IDLE with op_valid=1 and flush=0. In RUN or DONE, op_valid is ignored.
- MULT/MULTU: the 64-bit product is registered at the issue edge. Next cycle: we=2'b11, hiin=prod[63:32], loin=prod[31:0]. MULT is two's-complement; MULTU is unsigned.
- MTHI: next cycle we=2'b10, hiin=src_a, loin=0.
- MTLO: next cycle we=2'b01, loin=src_a, hiin=0.
- DIV/DIVU issue:
  - Latch the magnitudes of src_a/src_b. For DIV, take absolute values and record quotient sign = a[31]^b[31] and remainder sign = a[31]. For DIVU, both signs are 0.
  - Clear the remainder register and count=0, then go to RUN.
- RUN: one restoring shift-subtract step per cycle, MSB of dividend first. Increment count each cycle. After the step with count==31, go to DONE.
- DONE:
  - Apply the signs with a two's-complement negate where needed.
  - Register we=2'b11, hiin=remainder, loin=quotient.
  - Go to IDLE.
- Divide by zero: full latency, no trap. Result is LO=32'hFFFFFFFF, HI=src_a as issued, for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (result wraps).
- Flush in RUN or DONE: go to IDLE on the next edge, we stays 0 (no write), stall falls combinationally.
- Flush in the same cycle as op_valid: the issue is discarded and no write occurs.
- Cycles with no write drive we=0; hiin/loin are then don't-care but driven 0.

## Timing
- stall = ~rst & ((state!=IDLE & ~flush) | (state==IDLE & op_valid & ~flush & op∈{DIV,DIVU})). This is combinational, so the issuing instruction holds in EX from its issue cycle.
- MULT/MULTU/MTHI/MTLO issued in cycle T: we pulses high for exactly cycle T+1, with no stall.
- DIV/DIVU issued in cycle T:
  - RUN occupies T+1..T+32 and DONE occupies T+33.
  - stall is high T..T+33.
  - we=2'b11 during T+34; state is IDLE and stall is low in T+34.
- Back-to-back issue: a new op in T+34 is accepted, so its we pulse lands in T+35 or later.
- A MULT in consecutive cycles T and T+1 produces we pulses in T+1 and T+2.
- Async rst mid-divide: immediate return to IDLE, outputs at reset values, no write.

## Test plan
- MULT src_a=0xFFFFFFFF, src_b=2 -> next cycle we=11, hiin=0xFFFFFFFF, loin=0xFFFFFFFE. MULTU with the same operands -> hiin=0x00000001, loin=0xFFFFFFFE.
- DIV 7/-2 (src_b=0xFFFFFFFE) -> stall high for 34 cycles; then we=11, loin=0xFFFFFFFD, hiin=0x00000001. DIV -7/2 -> loin=0xFFFFFFFD, hiin=0xFFFFFFFF.
- DIVU 0xFFFFFFFF/0x10 -> at T+34, loin=0x0FFFFFFF, hiin=0x0000000F. DIVU 5/0 -> loin=0xFFFFFFFF, hiin=0x00000005.
- DIV issued, flush asserted at T+10 -> stall low at T+10, we never set, next MTHI 0x1234 accepted at T+11 -> we=10, hiin=0x1234 at T+12.
- DIV issued, rst pulsed asynchronously at T+20 -> we=0, stall=0, div_busy=0 immediately; MTLO 0xABCD issued after release -> we=01, loin=0xABCD.
- MTHI/MTLO/MULT issued in consecutive cycles -> we sequence 10, 01, 11 in the three following cycles with no stall; op_valid with op=0 or 7 -> we stays 0.
